cpu_out_receiver: RTL and testbench

Host-side receiver for the CPU output port: the consumer end of the CPU's startIO/clk/outFlag/endFlag/out interface. It raises startIO to launch a run, then captures each byte the CPU emits on its clk strobe. Captured bytes are buffered in a FIFO and presented on a valid/ready read port. It reports byte count, end-of-program and overflow status to the host.

---
 rtl/cpu_out_receiver.sv | 173 +++++++++++++++++
 tb/tb_cpu_out_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_out_receiver.sv
// Host-side receiver for the CPU output port.
// Launches a CPU run with startIO, captures each byte strobed out on the
// CPU's own clk, buffers the bytes in a first-word fall-through FIFO and
// reports byte count, completion and overflow back to the host.
module cpu_out_receiver #(
  parameter int DATAWIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int PTRWIDTH   = 4,
  parameter int COUNTWIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  startIO,
  input  logic                  cpuClk,
  input  logic                  outFlag,
  input  logic                  endFlag,
  input  logic [DATAWIDTH-1:0]  cpuOut,
  output logic [DATAWIDTH-1:0]  rdData,
  output logic                  rdValid,
  input  logic                  rdReady,
  output logic [COUNTWIDTH-1:0] byteCount,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RECV  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [PTRWIDTH:0]   PTR_ONE   = {{PTRWIDTH{1'b0}}, 1'b1};
  localparam logic [COUNTWIDTH-1:0] COUNT_ONE = {{(COUNTWIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTWIDTH-1:0] COUNT_MAX = {COUNTWIDTH{1'b1}};

  state_e state_q, state_d;

  // Synchronizer stages. Data and flags run one stage longer than the
  // two-flop clk synchronizer so that stage 3 lines up with strobe_q.
  logic                 cpuClkS1_q, cpuClkS2_q, cpuClkS3_q, strobe_q;
  logic                 outFlagS1_q, outFlagS2_q, outFlagS3_q;
  logic                 endFlagS1_q, endFlagS2_q, endFlagS3_q;
  logic [DATAWIDTH-1:0] dataS1_q, dataS2_q, dataS3_q;

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [PTRWIDTH:0]    wrPtr_q, rdPtr_q;
  logic [COUNTWIDTH-1:0] byteCount_q;
  logic                 overflow_q;

  logic pushReq, fifoClear, fifoEmpty, fifoFull, pop, pushAccept, pushDrop;

  // Bring the CPU-domain signals into our clock domain and detect clk rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpuClkS1_q  <= 1'b0;
      cpuClkS2_q  <= 1'b0;
      cpuClkS3_q  <= 1'b0;
      strobe_q    <= 1'b0;
      outFlagS1_q <= 1'b0;
      outFlagS2_q <= 1'b0;
      outFlagS3_q <= 1'b0;
      endFlagS1_q <= 1'b0;
      endFlagS2_q <= 1'b0;
      endFlagS3_q <= 1'b0;
      dataS1_q    <= '0;
      dataS2_q    <= '0;
      dataS3_q    <= '0;
    end else begin
      cpuClkS1_q  <= cpuClk;
      cpuClkS2_q  <= cpuClkS1_q;
      cpuClkS3_q  <= cpuClkS2_q;
      strobe_q    <= cpuClkS2_q & ~cpuClkS3_q;
      outFlagS1_q <= outFlag;
      outFlagS2_q <= outFlagS1_q;
      outFlagS3_q <= outFlagS2_q;
      endFlagS1_q <= endFlag;
      endFlagS2_q <= endFlagS1_q;
      endFlagS3_q <= endFlagS2_q;
      dataS1_q    <= cpuOut;
      dataS2_q    <= dataS1_q;
      dataS3_q    <= dataS2_q;
    end
  end

  // Run-control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and push request; dropping enable in RECV wins over a strobe.
  always_comb begin
    state_d   = state_q;
    pushReq   = 1'b0;
    fifoClear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = START;
      end
      START: begin
        fifoClear = 1'b1;
        state_d   = RECV;
      end
      RECV: begin
        if (!enable) begin
          state_d = DRAIN;
        end else if (strobe_q) begin
          pushReq = outFlagS3_q;
          if (endFlagS3_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifoEmpty) state_d = DONE;
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO status, handshake and status outputs.
  always_comb begin
    fifoEmpty  = (wrPtr_q == rdPtr_q);
    fifoFull   = (wrPtr_q[PTRWIDTH] != rdPtr_q[PTRWIDTH]) &&
                 (wrPtr_q[PTRWIDTH-1:0] == rdPtr_q[PTRWIDTH-1:0]);
    rdValid    = !fifoEmpty;
    rdData     = fifoEmpty ? '0 : mem_q[rdPtr_q[PTRWIDTH-1:0]];
    pop        = rdValid & rdReady;
    pushAccept = pushReq & (!fifoFull | pop);
    pushDrop   = pushReq & fifoFull & !pop;
    startIO    = (state_q == START) || (state_q == RECV);
    busy       = (state_q == START) || (state_q == RECV) || (state_q == DRAIN);
    done       = (state_q == DONE);
    byteCount  = byteCount_q;
    overflow   = overflow_q;
  end

  // FIFO pointers; the extra top bit separates full from empty.
  always_ff @(posedge clock) begin
    if (reset || fifoClear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pushAccept) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop)        rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // FIFO storage; contents are don't-care while empty because rdData is gated.
  always_ff @(posedge clock) begin
    if (pushAccept) mem_q[wrPtr_q[PTRWIDTH-1:0]] <= dataS3_q;
  end

  // Saturating accepted-byte counter and sticky overflow flag, cleared per run.
  always_ff @(posedge clock) begin
    if (reset || fifoClear) begin
      byteCount_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (pushAccept && (byteCount_q != COUNT_MAX)) byteCount_q <= byteCount_q + COUNT_ONE;
      if (pushDrop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_out_receiver.sv
// Self-checking bench for cpu_out_receiver: a table-driven main run, hand
// sequences for reset, overflow and full-with-pop, and a read-side scoreboard.
module tb_cpu_out_receiver;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        startIO;
  logic        cpuClk;
  logic        outFlag;
  logic        endFlag;
  logic [7:0]  cpuOut;
  logic [7:0]  rdData;
  logic        rdValid;
  logic        rdReady;
  logic [15:0] byteCount;
  logic        busy;
  logic        done;
  logic        overflow;

  int numChecks = 0;
  int numFails  = 0;
  logic [7:0] expQ [$];

  typedef struct {
    logic [7:0]  data;
    logic        of;
    logic        ef;
    bit          acc;
    logic [15:0] expCount;
    logic        expStartIO;
  } vec_t;

  vec_t vecs [5];

  cpu_out_receiver #(
    .DATAWIDTH (8),
    .DEPTH     (16),
    .PTRWIDTH  (4),
    .COUNTWIDTH(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .startIO  (startIO),
    .cpuClk   (cpuClk),
    .outFlag  (outFlag),
    .endFlag  (endFlag),
    .cpuOut   (cpuOut),
    .rdData   (rdData),
    .rdValid  (rdValid),
    .rdReady  (rdReady),
    .byteCount(byteCount),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  // Free-running clock: rising edges at 5, 15, 25 ...; inputs change on falling edges.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case a wait is never satisfied.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Read-side scoreboard: every accepted pop must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset && rdValid && rdReady) begin
        if (expQ.size() == 0) begin
          numChecks++;
          numFails++;
          $display("[TB] FAIL unexpected pop: actual 0x%0h, required no data", rdData);
        end else begin
          checkOutput("rdData pop", {24'd0, rdData}, {24'd0, expQ.pop_front()});
        end
      end
    end
  end

  // One CPU byte cycle; optionally raises rdReady exactly in the strobe cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic of, input logic ef,
                               input bit acc, input bit popAtStrobe);
    @(negedge clock);
    cpuOut  = b;
    outFlag = of;
    endFlag = ef;
    if (acc) expQ.push_back(b);
    @(negedge clock);
    cpuClk = 1'b1;
    repeat (3) @(negedge clock);
    if (popAtStrobe) rdReady = 1'b1;
    @(negedge clock);
    if (popAtStrobe) rdReady = 1'b0;
    cpuClk = 1'b0;
    repeat (3) @(negedge clock);
    outFlag = 1'b0;
    endFlag = 1'b0;
  endtask

  task automatic startRun();
    @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    checkOutput("startIO in START", {31'd0, startIO}, 32'd1);
    checkOutput("busy in START", {31'd0, busy}, 32'd1);
    @(negedge clock);
    checkOutput("overflow cleared by START", {31'd0, overflow}, 32'd0);
    checkOutput("byteCount cleared by START", {16'd0, byteCount}, 32'd0);
  endtask

  task automatic waitDone(input string name);
    int cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic endRun();
    @(negedge clock);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("done cleared in IDLE", {31'd0, done}, 32'd0);
    checkOutput("busy low in IDLE", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b1, 1'b0, 1'b1, 16'd1, 1'b1};
    vecs[1] = '{8'h42, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
    vecs[3] = '{8'h43, 1'b1, 1'b0, 1'b1, 16'd3, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0};

    reset   = 1'b1;
    enable  = 1'b0;
    cpuClk  = 1'b0;
    outFlag = 1'b0;
    endFlag = 1'b0;
    cpuOut  = 8'h00;
    rdReady = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset startIO", {31'd0, startIO}, 32'd0);
    checkOutput("reset rdValid", {31'd0, rdValid}, 32'd0);
    checkOutput("reset rdData", {24'd0, rdData}, 32'd0);
    checkOutput("reset byteCount", {16'd0, byteCount}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    // Main table-driven run with the consumer always ready.
    rdReady = 1'b1;
    startRun();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data, vecs[i].of, vecs[i].ef, vecs[i].acc, 1'b0);
      checkOutput($sformatf("vec%0d byteCount", i), {16'd0, byteCount}, {16'd0, vecs[i].expCount});
      checkOutput($sformatf("vec%0d startIO", i), {31'd0, startIO}, {31'd0, vecs[i].expStartIO});
      checkOutput($sformatf("vec%0d overflow", i), {31'd0, overflow}, 32'd0);
    end
    waitDone("done after table run");
    checkOutput("rdValid empty at done", {31'd0, rdValid}, 32'd0);
    endRun();

    // Byte carried together with endFlag, then strobes in DONE and IDLE.
    startRun();
    applyStimulus(8'h7F, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("end byte byteCount", {16'd0, byteCount}, 32'd1);
    checkOutput("end byte startIO", {31'd0, startIO}, 32'd0);
    waitDone("done after end byte");
    applyStimulus(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("strobe in DONE byteCount", {16'd0, byteCount}, 32'd1);
    checkOutput("strobe in DONE rdValid", {31'd0, rdValid}, 32'd0);
    endRun();
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("strobe in IDLE byteCount", {16'd0, byteCount}, 32'd1);
    checkOutput("strobe in IDLE rdValid", {31'd0, rdValid}, 32'd0);

    // Overflow: 20 bytes into a 16-deep FIFO with no reader.
    rdReady = 1'b0;
    startRun();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, (i < 16), 1'b0);
    end
    checkOutput("overflow set", {31'd0, overflow}, 32'd1);
    checkOutput("overflow byteCount", {16'd0, byteCount}, 32'd16);
    checkOutput("overflow head", {24'd0, rdData}, 32'h00);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    rdReady = 1'b1;
    waitDone("done after overflow drain");
    checkOutput("overflow sticky in DONE", {31'd0, overflow}, 32'd1);
    endRun();

    // Full FIFO with a pop in the same cycle as the push.
    rdReady = 1'b0;
    startRun();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("full+pop overflow", {31'd0, overflow}, 32'd0);
    checkOutput("full+pop byteCount", {16'd0, byteCount}, 32'd17);
    @(negedge clock);
    rdReady = 1'b1;
    enable  = 1'b0;
    @(negedge clock);
    checkOutput("enable drop startIO", {31'd0, startIO}, 32'd0);
    checkOutput("enable drop busy in DRAIN", {31'd0, busy}, 32'd1);
    checkOutput("enable drop done in DRAIN", {31'd0, done}, 32'd0);
    waitDone("done after enable drop");
    endRun();

    // Strobes with outFlag low capture nothing.
    startRun();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("outFlag low byteCount", {16'd0, byteCount}, 32'd0);
    checkOutput("outFlag low rdValid", {31'd0, rdValid}, 32'd0);
    @(negedge clock);
    enable = 1'b0;
    waitDone("done after empty run");
    endRun();

    // Reset in the middle of RECV with three bytes buffered, then restart.
    rdReady = 1'b0;
    startRun();
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("pre-reset byteCount", {16'd0, byteCount}, 32'd3);
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    checkOutput("mid-run reset startIO", {31'd0, startIO}, 32'd0);
    checkOutput("mid-run reset rdValid", {31'd0, rdValid}, 32'd0);
    checkOutput("mid-run reset rdData", {24'd0, rdData}, 32'd0);
    checkOutput("mid-run reset byteCount", {16'd0, byteCount}, 32'd0);
    checkOutput("mid-run reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    expQ.delete();
    rdReady = 1'b1;
    startRun();
    applyStimulus(8'h61, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h62, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("restart byteCount", {16'd0, byteCount}, 32'd2);
    waitDone("done after restart");
    endRun();

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
